// File: rtl/pte_barrier_pipe.sv
// pte_barrier_pipe
// Elastic valid/ready pipeline carrying page-table entries from the page-table
// walker to the TLB refill path. Each entry is classified as faulting when it
// enters, and the fault flag travels with it. Optionally, faulting entries
// leave with their PPN and d,a,x,w,r permission bits cleared. A flush drops
// every in-flight entry, and a registered occupancy count is kept alongside.

module pte_barrier_pipe #(
  parameter int PPN_W    = 44,
  parameter int STAGES   = 2,
  parameter bit SANITIZE = 1'b1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         io_flush,
  input  logic                         io_in_valid,
  output logic                         io_in_ready,
  input  logic [PPN_W-1:0]             io_in_ppn,
  input  logic [7:0]                   io_in_perm,
  output logic                         io_out_valid,
  input  logic                         io_out_ready,
  output logic [PPN_W-1:0]             io_out_ppn,
  output logic [7:0]                   io_out_perm,
  output logic                         io_out_fault,
  output logic [$clog2(STAGES+1)-1:0]  io_count
);

  localparam int CNT_W = $clog2(STAGES + 1);
  localparam int LAST  = STAGES - 1;

  // Permission bits that survive sanitising: g (bit 5), u (bit 4), v (bit 0).
  localparam logic [7:0] KEEP_PERM = 8'b0011_0001;

  // Per-stage storage.
  logic [STAGES-1:0] stg_valid;
  logic [PPN_W-1:0]  stg_ppn   [STAGES];
  logic [7:0]        stg_perm  [STAGES];
  logic [STAGES-1:0] stg_fault;

  // What each stage would load this cycle: stage 0 takes the input port,
  // every other stage takes its predecessor.
  logic [STAGES-1:0] src_valid;
  logic [PPN_W-1:0]  src_ppn   [STAGES];
  logic [7:0]        src_perm  [STAGES];
  logic [STAGES-1:0] src_fault;

  // ready_chain[k] is the ready of stage k; ready_chain[STAGES] is the consumer.
  logic [STAGES:0]   ready_chain;
  logic              ready_acc;

  logic              in_fault;
  logic              in_xfer;
  logic              out_xfer;
  logic              mask_out;

  // An entry faults when it is not valid, or when it is writable but not
  // readable (a reserved encoding).
  assign in_fault = ~io_in_perm[0] | (io_in_perm[2] & ~io_in_perm[1]);

  // Backward ready propagation. A flush blocks the consumer side so that
  // nothing leaves the pipe during the flush cycle.
  always_comb begin
    ready_acc = io_out_ready & ~io_flush;
    ready_chain = '0;
    ready_chain[STAGES] = ready_acc;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ready_acc = ~stg_valid[k] | ready_acc;
      ready_chain[k] = ready_acc;
    end
  end

  assign io_in_ready  = ready_chain[0] & ~io_flush;
  assign in_xfer      = io_in_valid & io_in_ready;
  assign io_out_valid = stg_valid[LAST] & ~io_flush;
  assign out_xfer     = io_out_valid & io_out_ready;

  // Source selection for every stage, wired once per stage.
  for (genvar k = 0; k < STAGES; k++) begin : g_src
    if (k == 0) begin : g_head
      assign src_valid[k] = in_xfer;
      assign src_ppn[k]   = io_in_ppn;
      assign src_perm[k]  = io_in_perm;
      assign src_fault[k] = in_fault;
    end else begin : g_body
      assign src_valid[k] = stg_valid[k-1];
      assign src_ppn[k]   = stg_ppn[k-1];
      assign src_perm[k]  = stg_perm[k-1];
      assign src_fault[k] = stg_fault[k-1];
    end
  end

  // Stage occupancy: a ready stage takes whatever its source offers (possibly
  // nothing); a flush empties every stage at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stg_valid <= '0;
    end else if (io_flush) begin
      stg_valid <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ready_chain[k]) begin
          stg_valid[k] <= src_valid[k];
        end
      end
    end
  end

  // Stage payload: loaded only when a real entry moves in, so a blocked or
  // emptied stage keeps its last contents; a flush leaves payloads untouched.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stg_fault <= '0;
      for (int k = 0; k < STAGES; k++) begin
        stg_ppn[k]  <= '0;
        stg_perm[k] <= '0;
      end
    end else if (!io_flush) begin
      for (int k = 0; k < STAGES; k++) begin
        if (ready_chain[k] && src_valid[k]) begin
          stg_ppn[k]   <= src_ppn[k];
          stg_perm[k]  <= src_perm[k];
          stg_fault[k] <= src_fault[k];
        end
      end
    end
  end

  // Occupancy count follows the net of input and output transfers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_count <= '0;
    end else if (io_flush) begin
      io_count <= '0;
    end else begin
      case ({in_xfer, out_xfer})
        2'b10:   io_count <= io_count + CNT_W'(1);
        2'b01:   io_count <= io_count - CNT_W'(1);
        default: io_count <= io_count;
      endcase
    end
  end

  // Output side: the last stage drives the ports, masked when sanitising.
  assign mask_out     = SANITIZE & stg_fault[LAST];
  assign io_out_ppn   = mask_out ? '0 : stg_ppn[LAST];
  assign io_out_perm  = mask_out ? (stg_perm[LAST] & KEEP_PERM) : stg_perm[LAST];
  assign io_out_fault = stg_fault[LAST];

endmodule

// File: tb/tb_pte_barrier_pipe.sv
// tb_pte_barrier_pipe
// Scoreboard bench for pte_barrier_pipe: expected entries are queued when an
// input transfer is seen and compared when an output transfer is seen. A
// second instance with sanitising disabled shares the same inputs.

module tb_pte_barrier_pipe;

  localparam int PPN_W  = 44;
  localparam int STAGES = 2;

  typedef struct {
    logic [PPN_W-1:0] ppn;
    logic [7:0]       perm;
    logic             fault;
    logic [PPN_W-1:0] raw_ppn;
    logic [7:0]       raw_perm;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset;
  logic             io_flush;
  logic             io_in_valid;
  logic             io_in_ready;
  logic [PPN_W-1:0] io_in_ppn;
  logic [7:0]       io_in_perm;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [PPN_W-1:0] io_out_ppn;
  logic [7:0]       io_out_perm;
  logic             io_out_fault;
  logic [1:0]       io_count;

  logic             raw_in_ready;
  logic             raw_out_valid;
  logic [PPN_W-1:0] raw_out_ppn;
  logic [7:0]       raw_out_perm;
  logic             raw_out_fault;
  logic [1:0]       raw_count;

  exp_t sbQueue[$];
  int   checkCount = 0;
  int   failCount  = 0;
  int   beatCount  = 0;

  pte_barrier_pipe #(.PPN_W(PPN_W), .STAGES(STAGES), .SANITIZE(1'b1)) dut (
    .clock(clock), .reset(reset), .io_flush(io_flush),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_ppn(io_in_ppn), .io_in_perm(io_in_perm),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_ppn(io_out_ppn), .io_out_perm(io_out_perm),
    .io_out_fault(io_out_fault), .io_count(io_count)
  );

  pte_barrier_pipe #(.PPN_W(PPN_W), .STAGES(STAGES), .SANITIZE(1'b0)) dut_raw (
    .clock(clock), .reset(reset), .io_flush(io_flush),
    .io_in_valid(io_in_valid), .io_in_ready(raw_in_ready),
    .io_in_ppn(io_in_ppn), .io_in_perm(io_in_perm),
    .io_out_valid(raw_out_valid), .io_out_ready(io_out_ready),
    .io_out_ppn(raw_out_ppn), .io_out_perm(raw_out_perm),
    .io_out_fault(raw_out_fault), .io_count(raw_count)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference behaviour of one entry: fault when !v or (w & !r); a sanitised
  // fault keeps only g, u and v and clears the PPN.
  function automatic exp_t makeExpected(input logic [PPN_W-1:0] ppn, input logic [7:0] perm);
    exp_t e;
    logic v, r, w;
    v = perm[0];
    r = perm[1];
    w = perm[2];
    e.fault    = !v || (w && !r);
    e.raw_ppn  = ppn;
    e.raw_perm = perm;
    e.ppn      = e.fault ? '0 : ppn;
    e.perm     = e.fault ? {2'b00, perm[5], perm[4], 3'b000, perm[0]} : perm;
    return e;
  endfunction

  // Scoreboard monitor, sampled on the falling edge away from the active edge.
  always @(negedge clock) begin
    if (reset) begin
      if (io_out_valid && io_out_ready) begin
        if (sbQueue.size() == 0) begin
          checkOutput("stale_entry", 64'(io_out_valid), 64'd0);
        end else begin
          exp_t e;
          e = sbQueue.pop_front();
          beatCount++;
          checkOutput("out_ppn",       64'(io_out_ppn),    64'(e.ppn));
          checkOutput("out_perm",      64'(io_out_perm),   64'(e.perm));
          checkOutput("out_fault",     64'(io_out_fault),  64'(e.fault));
          checkOutput("raw_out_valid", 64'(raw_out_valid), 64'd1);
          checkOutput("raw_out_ppn",   64'(raw_out_ppn),   64'(e.raw_ppn));
          checkOutput("raw_out_perm",  64'(raw_out_perm),  64'(e.raw_perm));
          checkOutput("raw_out_fault", 64'(raw_out_fault), 64'(e.fault));
        end
      end
      if (io_in_valid && io_in_ready) begin
        sbQueue.push_back(makeExpected(io_in_ppn, io_in_perm));
      end
    end
  end

  // Waits (bounded) for the entry currently on the input to be accepted.
  task automatic waitAccept(input string tag);
    bit accepted;
    accepted = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (io_in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    @(posedge clock);
    #1;
    io_in_valid = 1'b0;
    if (!accepted) checkOutput({tag, "_accept_timeout"}, 64'd0, 64'd1);
  endtask

  // Drives one entry and waits for its acceptance.
  task automatic applyStimulus(input logic [PPN_W-1:0] ppn, input logic [7:0] perm);
    io_in_valid = 1'b1;
    io_in_ppn   = ppn;
    io_in_perm  = perm;
    waitAccept("push");
  endtask

  // Called right after an acceptance edge with an empty, unstalled pipe.
  task automatic latencyCheck(input string tag);
    @(negedge clock);
    checkOutput({tag, "_lat_early"}, 64'(io_out_valid), 64'd0);
    @(negedge clock);
    checkOutput({tag, "_lat_hit"}, 64'(io_out_valid), 64'd1);
  endtask

  // Lets the pipe empty (bounded) and confirms it is empty.
  task automatic drainPipe(input string tag);
    for (int i = 0; i < 50; i++) begin
      if (sbQueue.size() == 0) break;
      @(posedge clock);
      #1;
    end
    checkOutput({tag, "_drain_queue"}, 64'(sbQueue.size()), 64'd0);
    checkOutput({tag, "_drain_count"}, 64'(io_count), 64'd0);
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int beatsBefore;
    reset        = 1'b0;
    io_flush     = 1'b0;
    io_in_valid  = 1'b0;
    io_in_ppn    = '0;
    io_in_perm   = '0;
    io_out_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_out_valid", 64'(io_out_valid), 64'd0);
    checkOutput("rst_count",     64'(io_count),     64'd0);
    checkOutput("rst_in_ready",  64'(io_in_ready),  64'd1);
    checkOutput("rst_out_ppn",   64'(io_out_ppn),   64'd0);
    checkOutput("rst_out_perm",  64'(io_out_perm),  64'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Single entry, latency STAGES.
    applyStimulus(44'h123, 8'h0F);
    latencyCheck("t1");
    drainPipe("t1");

    // Back-to-back stream at full rate.
    beatCount = 0;
    for (int i = 0; i < 10; i++) begin
      io_in_valid = 1'b1;
      io_in_ppn   = 44'h200 + 44'(i);
      io_in_perm  = 8'h0F;
      @(negedge clock);
      checkOutput("t2_in_ready", 64'(io_in_ready), 64'd1);
      if (i >= 2) begin
        checkOutput("t2_count",     64'(io_count),     64'd2);
        checkOutput("t2_out_valid", 64'(io_out_valid), 64'd1);
      end
      @(posedge clock);
      #1;
    end
    io_in_valid = 1'b0;
    drainPipe("t2");
    checkOutput("t2_beats", 64'(beatCount), 64'd10);

    // Backpressure: two fit, the third waits until the consumer is ready.
    io_out_ready = 1'b0;
    applyStimulus(44'h300, 8'h0F);
    applyStimulus(44'h301, 8'h0B);
    io_in_valid = 1'b1;
    io_in_ppn   = 44'h302;
    io_in_perm  = 8'h03;
    @(negedge clock);
    checkOutput("t3_in_ready_full", 64'(io_in_ready),  64'd0);
    checkOutput("t3_count_full",    64'(io_count),     64'd2);
    checkOutput("t3_out_valid",     64'(io_out_valid), 64'd1);
    checkOutput("t3_hold_ppn",      64'(io_out_ppn),   64'h300);
    @(posedge clock);
    #1;
    @(negedge clock);
    checkOutput("t3_hold_ppn2",     64'(io_out_ppn),   64'h300);
    checkOutput("t3_in_ready_still", 64'(io_in_ready), 64'd0);
    @(posedge clock);
    #1;
    io_out_ready = 1'b1;
    waitAccept("t3");
    drainPipe("t3");

    // Faulting entries: w without r, and v clear with g,u set.
    applyStimulus(44'hABC, 8'h05);
    applyStimulus(44'h5A5, 8'h3E);
    drainPipe("t4");

    // Flush of a full pipe.
    io_out_ready = 1'b0;
    applyStimulus(44'h500, 8'h0F);
    applyStimulus(44'h501, 8'h0F);
    beatsBefore = beatCount;
    io_flush    = 1'b1;
    io_in_valid = 1'b1;
    io_in_ppn   = 44'h5FF;
    io_in_perm  = 8'h0F;
    @(negedge clock);
    checkOutput("t5_flush_out_valid", 64'(io_out_valid), 64'd0);
    checkOutput("t5_flush_in_ready",  64'(io_in_ready),  64'd0);
    @(posedge clock);
    #1;
    io_flush     = 1'b0;
    io_in_valid  = 1'b0;
    io_out_ready = 1'b1;
    sbQueue.delete();
    @(negedge clock);
    checkOutput("t5_count",     64'(io_count),     64'd0);
    checkOutput("t5_in_ready",  64'(io_in_ready),  64'd1);
    checkOutput("t5_out_valid", 64'(io_out_valid), 64'd0);
    repeat (5) @(posedge clock);
    #1;
    checkOutput("t5_no_stale", 64'(beatCount), 64'(beatsBefore));

    // Asynchronous reset in the middle of a stream.
    io_in_valid = 1'b1;
    io_in_ppn   = 44'h600;
    io_in_perm  = 8'h0F;
    @(posedge clock);
    #1;
    io_in_ppn = 44'h601;
    @(posedge clock);
    #3;
    reset       = 1'b0;
    io_in_valid = 1'b0;
    #1;
    checkOutput("t6_rst_out_valid", 64'(io_out_valid), 64'd0);
    checkOutput("t6_rst_count",     64'(io_count),     64'd0);
    sbQueue.delete();
    @(posedge clock);
    @(posedge clock);
    #3;
    reset = 1'b1;
    @(posedge clock);
    #1;
    applyStimulus(44'h6AA, 8'h07);
    latencyCheck("t6");
    drainPipe("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
